// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store with a fixed, parameterised
// response latency. Storage is a flat word array indexed by the word address bits.
module dmem_responder #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDRW       = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                dmem_req_i,
    input  logic                dmem_we_i,
    input  logic [ADDRW-1:0]    dmem_addr_i,
    input  logic [XLEN/8-1:0]   dmem_wmask_i,
    input  logic [XLEN-1:0]     dmem_wdata_i,
    output logic [XLEN-1:0]     dmem_rdata_o,
    output logic                dmem_resp_o,
    output logic                busy_o
);

    localparam int unsigned IdxW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned NLanes = XLEN / 8;
    // WAIT spends LATENCY-1 cycles: counter runs CntInit..0, RESP follows.
    localparam logic [3:0]  CntInit = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic            accept;
    logic [IdxW-1:0] idx;
    logic            unused_addr;

    // Low two bits select a byte within the word and high bits wrap; neither is decoded.
    assign unused_addr = ^dmem_addr_i;

    // Requests are only taken in IDLE; gating with reset keeps a held store from
    // writing while the block is held in reset.
    assign accept = rst_i && (state_q == StIdle) && dmem_req_i;
    assign idx    = dmem_addr_i[2 +: IdxW];

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (dmem_req_i) begin
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, counter and load-data registers; reset aborts any transaction.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept && !dmem_we_i) begin
                rdata_q <= mem_q[idx];
            end
        end
    end

    // Byte-masked store on the accepting edge; storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (accept && dmem_we_i) begin
            for (int unsigned i = 0; i < NLanes; i++) begin
                if (dmem_wmask_i[i]) begin
                    mem_q[idx][8*i +: 8] <= dmem_wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign dmem_rdata_o = rdata_q;
    assign dmem_resp_o  = (state_q == StResp);
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a LATENCY=2 instance carries the functional tests; LATENCY=1 and 5
// instances share the same stimulus for the latency/spacing sweep.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] wdata = '0;

    logic [31:0] rdata2, rdata1, rdata5;
    logic        resp2, resp1, resp5;
    logic        busy2, busy1, busy5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(32), .ADDRW(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .dmem_req_i(req), .dmem_we_i(we), .dmem_addr_i(addr),
        .dmem_wmask_i(wmask), .dmem_wdata_i(wdata), .dmem_rdata_o(rdata2),
        .dmem_resp_o(resp2), .busy_o(busy2)
    );

    dmem_responder #(.XLEN(32), .ADDRW(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .dmem_req_i(req), .dmem_we_i(we), .dmem_addr_i(addr),
        .dmem_wmask_i(wmask), .dmem_wdata_i(wdata), .dmem_rdata_o(rdata1),
        .dmem_resp_o(resp1), .busy_o(busy1)
    );

    dmem_responder #(.XLEN(32), .ADDRW(32), .DEPTH_WORDS(1024), .LATENCY(5)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .dmem_req_i(req), .dmem_we_i(we), .dmem_addr_i(addr),
        .dmem_wmask_i(wmask), .dmem_wdata_i(wdata), .dmem_rdata_o(rdata5),
        .dmem_resp_o(resp5), .busy_o(busy5)
    );

    // One transaction on the LATENCY=2 instance. Starts and ends at a negedge with the
    // DUT idle; lat is posedges from acceptance to the resp sample (-1 on timeout).
    task automatic txn(input logic t_we, input logic [31:0] t_addr, input logic [3:0] t_mask,
                       input logic [31:0] t_data, output int lat, output logic [31:0] rd);
        req   = 1'b1;
        we    = t_we;
        addr  = t_addr;
        wmask = t_mask;
        wdata = t_data;
        @(posedge clk);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (resp2) begin
                lat = i;
                break;
            end
        end
        rd  = rdata2;
        req = 1'b0;
        @(negedge clk);
    endtask

    // Extract latency, accept spacing and pulse width from sampled busy/resp traces.
    function automatic void analyze(input logic [23:0] b, input logic [23:0] r,
                                    output int lat, output int sp, output int w);
        int  rise1 = -1;
        int  rise2 = -1;
        int  rsp   = -1;
        logic prev = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (b[i] && !prev) begin
                if (rise1 < 0) rise1 = i;
                else if (rise2 < 0) rise2 = i;
            end
            if (r[i] && rsp < 0) rsp = i;
            prev = b[i];
        end
        lat = (rise1 >= 0 && rsp >= 0) ? rsp - rise1 + 1 : -1;
        sp  = (rise1 >= 0 && rise2 >= 0) ? rise2 - rise1 : -1;
        w   = 0;
        if (rsp >= 0) begin
            for (int i = rsp; i < 24; i++) begin
                if (!r[i]) break;
                w++;
            end
        end
    endfunction

    task automatic test_reset;
        #1;
        checks++;
        if (resp2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: got %b want 0", resp2);
        end
        checks++;
        if (busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b want 0", busy2);
        end
        checks++;
        if (rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 00000000", rdata2);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_store_load;
        int          lat;
        logic [31:0] rd;
        txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, lat, rd);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL store_latency: got %0d want 2", lat);
        end
        txn(1'b0, 32'h10, 4'h0, 32'h0, lat, rd);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL load_latency: got %0d want 2", lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_data: got %h want deadbeef", rd);
        end
        // Output holds outside RESP.
        repeat (3) @(negedge clk);
        checks++;
        if (rdata2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rdata_hold: got %h want deadbeef", rdata2);
        end
    endtask

    task automatic test_partial;
        int          lat;
        logic [31:0] rd;
        txn(1'b1, 32'h20, 4'hF, 32'h11223344, lat, rd);
        txn(1'b1, 32'h20, 4'b0100, 32'h00AA0000, lat, rd);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_keeps_rdata: got %h want deadbeef", rd);
        end
        txn(1'b0, 32'h22, 4'h0, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'h11AA3344) begin
            errors++;
            $display("FAIL partial_store: got %h want 11aa3344", rd);
        end
        txn(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, lat, rd);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL zero_mask_resp: got lat %0d want 2", lat);
        end
        txn(1'b0, 32'h20, 4'h0, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'h11AA3344) begin
            errors++;
            $display("FAIL zero_mask_data: got %h want 11aa3344", rd);
        end
    endtask

    task automatic test_wrap;
        int          lat;
        logic [31:0] rd;
        txn(1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, lat, rd);
        txn(1'b0, 32'h0000, 4'h0, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL wrap_load: got %h want cafef00d", rd);
        end
        // 0xFFFFF013 decodes to word 4 (byte 0x10).
        txn(1'b0, 32'hFFFFF013, 4'h0, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL high_bits_ignored: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_field_change;
        int          lat = -1;
        logic [31:0] rd;
        req   = 1'b1;
        we    = 1'b0;
        addr  = 32'h10;
        wmask = 4'h0;
        wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        // In WAIT: scramble every field, including a store of ones to 0x20.
        addr  = 32'h20;
        we    = 1'b1;
        wmask = 4'hF;
        wdata = 32'hFFFFFFFF;
        for (int i = 2; i <= 20; i++) begin
            if (resp2) begin
                lat = i - 1;
                break;
            end
            @(negedge clk);
        end
        rd  = rdata2;
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (rd !== 32'hDEADBEEF || lat !== 2) begin
            errors++;
            $display("FAIL field_change: got %h lat %0d want deadbeef lat 2", rd, lat);
        end
        txn(1'b0, 32'h20, 4'h0, 32'h0, lat, rd);
        checks++;
        if (rd !== 32'h11AA3344) begin
            errors++;
            $display("FAIL field_change_no_store: got %h want 11aa3344", rd);
        end
    endtask

    task automatic test_reset_mid;
        int          lat;
        logic [31:0] rd;
        logic        saw_resp = 1'b0;
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h30;
        wmask = 4'hF;
        wdata = 32'h5A5A1234;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy2 !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: got %b want 1", busy2);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({resp2, busy2} !== 2'b00 || rdata2 !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got resp %b busy %b rdata %h want 0 0 00000000",
                     resp2, busy2, rdata2);
        end
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp2) saw_resp = 1'b1;
        end
        checks++;
        if (saw_resp !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_pulse: got pulse 1 want 0");
        end
        rst = 1'b1;
        txn(1'b0, 32'h30, 4'h0, 32'h0, lat, rd);
        checks++;
        if (lat !== 2 || rd !== 32'h5A5A1234) begin
            errors++;
            $display("FAIL post_reset_load: got %h lat %0d want 5a5a1234 lat 2", rd, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [23:0] b1, r1, b2, r2, b5, r5;
        int          lat, sp, w;
        rst = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        req   = 1'b1;
        we    = 1'b0;
        addr  = 32'h10;
        wmask = 4'h0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            b1[i] = busy1;
            r1[i] = resp1;
            b2[i] = busy2;
            r2[i] = resp2;
            b5[i] = busy5;
            r5[i] = resp5;
        end
        req = 1'b0;
        analyze(b1, r1, lat, sp, w);
        checks++;
        if (lat !== 1 || sp !== 2 || w !== 1) begin
            errors++;
            $display("FAIL sweep_lat1: got lat %0d spacing %0d width %0d want 1 2 1", lat, sp, w);
        end
        analyze(b2, r2, lat, sp, w);
        checks++;
        if (lat !== 2 || sp !== 3 || w !== 1) begin
            errors++;
            $display("FAIL sweep_lat2: got lat %0d spacing %0d width %0d want 2 3 1", lat, sp, w);
        end
        analyze(b5, r5, lat, sp, w);
        checks++;
        if (lat !== 5 || sp !== 6 || w !== 1) begin
            errors++;
            $display("FAIL sweep_lat5: got lat %0d spacing %0d width %0d want 5 6 1", lat, sp, w);
        end
        checks++;
        if (rdata5 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sweep_lat5_data: got %h want deadbeef", rdata5);
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_store_load;
        test_partial;
        test_wrap;
        test_field_change;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
Parameters:
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDRW, default 32, meaning byte address width.
REQ-003 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning storage size in XLEN-bit words; it must be a power of two.
REQ-004 The block SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to the response pulse; legal range is 1..15.

Ports:
REQ-005 The block SHALL have the port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have the port rst_i, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have the port dmem_req_i, input, 1 bit: a load or store request is present. The requester holds it, with its fields stable, until it sees dmem_resp_o.
REQ-008 The block SHALL have the port dmem_we_i, input, 1 bit: 1 means store, 0 means load.
REQ-009 The block SHALL have the port dmem_addr_i, input, ADDRW bits: byte address.
REQ-010 The block SHALL have the port dmem_wmask_i, input, XLEN/8 bits: store byte-lane enables.
REQ-011 The block SHALL have the port dmem_wdata_i, input, XLEN bits: store data, already lane-aligned.
REQ-012 The block SHALL have the port dmem_rdata_o, output, XLEN bits: full aligned word read. The requester performs byte/half extraction and sign extension.
REQ-013 The block SHALL have the port dmem_resp_o, output, 1 bit: one-cycle completion pulse for loads and stores alike.
REQ-014 The block SHALL have the port busy_o, output, 1 bit: a transaction is in flight (state is not IDLE).

Function
REQ-015 The block SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 IDLE: when dmem_req_i=1, the block SHALL accept the request on that edge. It goes to RESP if LATENCY=1; otherwise it goes to WAIT with the counter loaded to LATENCY-2.
REQ-017 WAIT: the block SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
REQ-018 RESP: dmem_resp_o SHALL be 1 for exactly this one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-019 The response SHALL occur exactly LATENCY cycles after the accepting edge.
REQ-020 While dmem_req_i is held high in the RESP cycle, the block SHALL NOT accept it again. Accepting a new request requires IDLE, so back-to-back requests are spaced LATENCY+1 cycles apart.
REQ-021 Word index SHALL be dmem_addr_i[2 +: log2(DEPTH_WORDS)]. Higher address bits SHALL be ignored, so addresses wrap modulo DEPTH_WORDS*4. Address bits [1:0] SHALL be ignored.
REQ-022 Store: on the accepting edge, the block SHALL write each byte lane i whose dmem_wmask_i[i]=1. Lanes with the mask bit at 0 SHALL be unchanged. A store with wmask=0 changes no storage but still completes with a response.
REQ-023 Load: on the accepting edge, the block SHALL capture the addressed word into an output register. It SHALL drive that register on dmem_rdata_o during RESP.
REQ-024 A load accepted right after a store to the same word SHALL return the updated data.
REQ-025 dmem_rdata_o SHALL hold its last value outside RESP and SHALL NOT change on stores.
REQ-026 Request fields SHALL be sampled only on the accepting edge. Changes, or deassertion of dmem_req_i, during WAIT or RESP SHALL have no effect; an accepted transaction always completes.
REQ-027 busy_o SHALL be 1 in WAIT and RESP and 0 in IDLE.

Reset
REQ-028 While rst_i=0, the block SHALL force state to IDLE, the counter to 0, dmem_resp_o=0, dmem_rdata_o=0 and busy_o=0, immediately and independent of clk_i.
REQ-029 Reset asserted mid-transaction SHALL abort it with no response pulse. A store accepted before reset remains written.
REQ-030 Storage contents SHALL NOT be initialised by reset.
REQ-031 After rst_i deasserts, the first rising edge with dmem_req_i=1 SHALL be accepted.

Verification
REQ-032 Store then load, LATENCY=2: store addr 0x10, wmask 4'hF, wdata 0xDEADBEEF, then load addr 0x10 -> each dmem_resp_o pulse occurs 2 cycles after acceptance; the load returns 0xDEADBEEF.
REQ-033 Partial store: word 0x20 holds 0x11223344; store wmask 4'b0100, wdata 0x00AA0000; load 0x22 -> returns 0x11AA3344.
REQ-034 Latency sweep LATENCY=1 and 5: request held high continuously -> response 1 or 5 cycles after acceptance; accept-to-accept spacing is 2 or 6 cycles; resp width is always 1 cycle.
REQ-035 Wrap-around, DEPTH_WORDS=1024: store 0xCAFEF00D at 0x1000 -> a load at 0x0000 returns 0xCAFEF00D.
REQ-036 Reset mid-operation: assert rst_i=0 in WAIT -> dmem_resp_o=0, busy_o=0 and dmem_rdata_o=0 immediately, with no pulse; after release, a new load completes normally.
REQ-037 Field change after accept: load 0x10 accepted, then addr driven to 0x20 during WAIT -> data from 0x10 is returned.
